dat_receiver: RTL and testbench

- Card-to-host half of the SD DAT path. Runs alongside the host-to-card DAT transmitter.
- Samples the 4-bit DAT bus from the card and detects the start bit. Assembles data nibbles into 32-bit words and pushes them into the receive FIFO.
- Checks the per-line CRC16 and the end bit, then reports completion and errors to the register/control logic.
- Handles one block per `start` request.

---
 rtl/dat_receiver_if.sv | 33 +++
 rtl/dat_receiver.sv | 139 +++++++++++++
 tb/tb_dat_receiver.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dat_receiver_if.sv
// Signal bundle between the SD DAT receive path and its controller, FIFO and card pins.
// state_dbg exposes the receiver FSM state for checkers and waveform debug.
interface dat_receiver_if #(
    parameter int TO_W = 16,
    parameter int BS_W = 12
);
    logic            start;
    logic [BS_W-1:0] block_size;
    logic [TO_W-1:0] timeout;
    logic [3:0]      card_in;
    logic            fifo_full;
    // push is a one-cycle write strobe with no back-pressure: fifo_full is sampled on the
    // edge that completes a word, and a word that meets fifo_full=1 is dropped, never retried.
    logic [31:0]     word_out;
    logic            push;
    logic            busy;
    logic            done;
    logic            crc_err;
    logic            end_err;
    logic            timeout_err;
    logic            overrun_err;
    logic [2:0]      state_dbg;

    modport master (
        output start, block_size, timeout, card_in, fifo_full,
        input  word_out, push, busy, done, crc_err, end_err, timeout_err, overrun_err, state_dbg
    );

    modport slave (
        input  start, block_size, timeout, card_in, fifo_full,
        output word_out, push, busy, done, crc_err, end_err, timeout_err, overrun_err, state_dbg
    );
endinterface

// File: rtl/dat_receiver.sv
// SD card-to-host DAT receiver: start-bit search, nibble-to-word packing, per-line CRC16
// and end-bit checking for one block per start request.
module dat_receiver #(
    parameter int TO_W = 16,
    parameter int BS_W = 12
) (
    input  logic          clk,
    input  logic          reset,
    dat_receiver_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        DATA       = 3'd2,
        CRC        = 3'd3,
        END_BIT    = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [BS_W-1:0] bs_lat;
    logic [TO_W-1:0] to_lat, wait_cnt;
    logic [BS_W:0]   nib_cnt, last_nib;
    logic [3:0]      crc_cnt;
    logic [31:0]     asm_word, asm_nxt, word_q;
    logic [15:0]     crc_q [4];
    logic            push_q, crc_err_q, end_err_q, timeout_err_q, overrun_err_q;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign last_nib = {bs_lat, 1'b0} - (BS_W + 1)'(1);

    // Nibble k of a word lands in byte k/2; even k is the high half of that byte.
    always_comb begin
        asm_nxt = asm_word;
        asm_nxt[{nib_cnt[2:1], ~nib_cnt[0], 2'b00} +: 4] = bus.card_in;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.start) state_nxt = WAIT_START;
            WAIT_START: begin
                if (bus.card_in == 4'h0)                          state_nxt = DATA;
                else if (to_lat != '0 && wait_cnt == to_lat)      state_nxt = DONE;
            end
            DATA:       if (nib_cnt == last_nib) state_nxt = CRC;
            CRC:        if (crc_cnt == 4'd15)    state_nxt = END_BIT;
            END_BIT:    state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bs_lat        <= '0;
            to_lat        <= '0;
            wait_cnt      <= '0;
            nib_cnt       <= '0;
            crc_cnt       <= '0;
            asm_word      <= '0;
            word_q        <= '0;
            push_q        <= 1'b0;
            crc_err_q     <= 1'b0;
            end_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) crc_q[i] <= '0;
        end else begin
            push_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bs_lat        <= bus.block_size;
                    to_lat        <= bus.timeout;
                    wait_cnt      <= '0;
                    nib_cnt       <= '0;
                    crc_cnt       <= '0;
                    crc_err_q     <= 1'b0;
                    end_err_q     <= 1'b0;
                    timeout_err_q <= 1'b0;
                    overrun_err_q <= 1'b0;
                    for (int i = 0; i < 4; i++) crc_q[i] <= '0;
                end
                WAIT_START: begin
                    if (wait_cnt != '1) wait_cnt <= wait_cnt + TO_W'(1);
                    if (bus.card_in == 4'h0) begin
                        nib_cnt <= '0;
                        crc_cnt <= '0;
                    end else if (to_lat != '0 && wait_cnt == to_lat) begin
                        timeout_err_q <= 1'b1;
                    end
                end
                DATA: begin
                    asm_word <= asm_nxt;
                    for (int i = 0; i < 4; i++) crc_q[i] <= crc16_step(crc_q[i], bus.card_in[i]);
                    if (nib_cnt != last_nib) nib_cnt <= nib_cnt + (BS_W + 1)'(1);
                    if (nib_cnt[2:0] == 3'd7) begin
                        if (bus.fifo_full) begin
                            overrun_err_q <= 1'b1;
                        end else begin
                            push_q <= 1'b1;
                            word_q <= asm_nxt;
                        end
                    end
                end
                CRC: begin
                    // The card sends its CRC MSB first; our remainder shifts out in step with it.
                    for (int i = 0; i < 4; i++) begin
                        if (bus.card_in[i] != crc_q[i][15]) crc_err_q <= 1'b1;
                        crc_q[i] <= {crc_q[i][14:0], 1'b0};
                    end
                    if (crc_cnt != 4'd15) crc_cnt <= crc_cnt + 4'd1;
                end
                END_BIT: if (bus.card_in != 4'hF) end_err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.word_out    = word_q;
    assign bus.push        = push_q;
    assign bus.busy        = (state != IDLE) && (state != DONE);
    assign bus.done        = (state == DONE);
    assign bus.crc_err     = crc_err_q;
    assign bus.end_err     = end_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun_err = overrun_err_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_dat_receiver.sv
// Bench for dat_receiver: table of block scenarios plus random blocks, checked against a
// long-division CRC model and a byte-order word model with a push scoreboard.
module tb_dat_receiver;
    localparam int TO_W = 16;
    localparam int BS_W = 12;

    logic clk;
    logic reset;
    dat_receiver_if #(.TO_W(TO_W), .BS_W(BS_W)) bus ();

    dat_receiver #(.TO_W(TO_W), .BS_W(BS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          push_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [7:0]  blk[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.push) begin
            push_cnt++;
            got_q.push_back(bus.word_out);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got=%h expected=no push", bus.word_out);
            end else begin
                check("word", bus.word_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, by long division.
    function automatic logic [15:0] crc_line(input int ln);
        bit          m[$];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h11021;
        foreach (blk[b]) begin
            m.push_back(blk[b][4 + ln]);
            m.push_back(blk[b][ln]);
        end
        repeat (16) m.push_back(1'b0);
        for (int i = 0; i + 16 < m.size(); i++)
            if (m[i]) for (int j = 0; j <= 16; j++) m[i + j] = m[i + j] ^ g[16 - j];
        for (int k = 0; k < 16; k++) r[15 - k] = m[m.size() - 16 + k];
        return r;
    endfunction

    typedef struct {
        string        name;
        int           bs;
        int           to;
        int           gap;
        int           pattern;   // 0: bytes 1,2,3..  1: all 0xFF  2: random
        logic [3:0]   crc_flip;  // lines whose CRC bit 0 is corrupted
        logic [3:0]   end_nib;
        logic [511:0] full_mask; // words that meet fifo_full at their push edge
        int           abort_at;  // nibble index at which reset is asserted, -1 none
        logic         e_crc;
        logic         e_end;
        logic         e_ovr;
        int           e_push;
    } vec_t;

    function automatic vec_t mk(input string name, input int bs, input int to, input int gap,
                                input int pattern, input logic [3:0] flip, input logic [3:0] end_nib,
                                input logic [511:0] fm, input int abort_at, input logic e_crc,
                                input logic e_end, input logic e_ovr, input int e_push);
        vec_t v;
        v.name = name; v.bs = bs; v.to = to; v.gap = gap; v.pattern = pattern;
        v.crc_flip = flip; v.end_nib = end_nib; v.full_mask = fm; v.abort_at = abort_at;
        v.e_crc = e_crc; v.e_end = e_end; v.e_ovr = e_ovr; v.e_push = e_push;
        return v;
    endfunction

    function automatic logic [3:0] flags();
        return {bus.crc_err, bus.end_err, bus.timeout_err, bus.overrun_err};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_block(input vec_t v);
        logic [15:0] crc_v [4];
        logic [7:0]  bt;
        logic        done_seen;
        int          nwords;
        done_seen = 1'b0;
        blk.delete();
        for (int i = 0; i < v.bs; i++) begin
            case (v.pattern)
                0:       blk.push_back(8'(i + 1));
                1:       blk.push_back(8'hFF);
                default: blk.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        nwords = v.bs / 4;
        if (v.abort_at < 0)
            for (int w = 0; w < nwords; w++)
                if (!v.full_mask[w])
                    exp_q.push_back({blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]});
        for (int ln = 0; ln < 4; ln++)
            crc_v[ln] = crc_line(ln) ^ (v.crc_flip[ln] ? 16'h0001 : 16'h0000);
        push_cnt = 0;
        got_q.delete();

        bus.start      = 1'b1;
        bus.block_size = BS_W'(v.bs);
        bus.timeout    = TO_W'(v.to);
        bus.card_in    = 4'hF;
        @(negedge clk);
        bus.start = 1'b0;
        check({v.name, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        check({v.name, "_flags_cleared"}, 32'(flags()), 32'd0);

        for (int g = 0; g < v.gap; g++) begin
            bus.card_in = 4'($urandom_range(1, 15));
            @(negedge clk);
        end
        bus.card_in = 4'h0;
        @(negedge clk);
        for (int n = 0; n < 2 * v.bs; n++) begin
            if (n == v.abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check({v.name, "_abort_busy"}, 32'(bus.busy), 32'd0);
                check({v.name, "_abort_done"}, 32'(bus.done), 32'd0);
                check({v.name, "_abort_push"}, 32'(bus.push), 32'd0);
                check({v.name, "_abort_word"}, bus.word_out, 32'd0);
                check({v.name, "_abort_flags"}, 32'(flags()), 32'd0);
                reset = 1'b0;
                return;
            end
            bt = blk[n / 2];
            bus.card_in   = (n % 2 == 0) ? bt[7:4] : bt[3:0];
            bus.fifo_full = (n % 8 == 7) ? v.full_mask[n / 8] : 1'($urandom_range(0, 1));
            @(negedge clk);
            done_seen |= bus.done;
        end
        for (int k = 0; k < 16; k++) begin
            for (int ln = 0; ln < 4; ln++) bus.card_in[ln] = crc_v[ln][15 - k];
            bus.fifo_full = 1'($urandom_range(0, 1));
            @(negedge clk);
            done_seen |= bus.done;
        end
        bus.card_in = v.end_nib;
        @(negedge clk);
        check({v.name, "_no_early_done"}, 32'(done_seen), 32'd0);
        check({v.name, "_done_timing"}, 32'(bus.done), 32'd1);
        check({v.name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        check({v.name, "_flags"}, 32'(flags()), 32'({v.e_crc, v.e_end, 1'b0, v.e_ovr}));
        // A start in the DONE cycle must be ignored.
        bus.start     = 1'b1;
        bus.card_in   = 4'hF;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check({v.name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({v.name, "_start_in_done_ignored"}, 32'(bus.busy), 32'd0);
        check({v.name, "_push_count"}, 32'(push_cnt), 32'(v.e_push));
        check({v.name, "_words_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_timeout(input int to);
        logic done_seen;
        done_seen = 1'b0;
        push_cnt  = 0;
        bus.start      = 1'b1;
        bus.block_size = BS_W'(8);
        bus.timeout    = TO_W'(to);
        bus.card_in    = 4'hF;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= to + 1; k++) begin
            done_seen |= bus.done;
            @(negedge clk);
        end
        check("timeout_no_early_done", 32'(done_seen), 32'd0);
        check("timeout_done_timing", 32'(bus.done), 32'd1);
        check("timeout_flags", 32'(flags()), 32'b0010);
        check("timeout_no_push", 32'(push_cnt), 32'd0);
        @(negedge clk);
        check("timeout_done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    // ---------------- test ----------------
    vec_t vecs[$];

    initial begin
        logic [511:0] fm;
        logic [3:0]   flip, endn;
        int           bs, gap, to, nw;

        vecs.push_back(mk("basic",       8,  100, 0,  0, 4'b0000, 4'hF, 512'd0,       -1, 0, 0, 0, 2));
        vecs.push_back(mk("reset_mid",   8,  100, 0,  0, 4'b0000, 4'hF, 512'd0,        5, 0, 0, 0, 0));
        vecs.push_back(mk("after_reset", 8,  100, 2,  0, 4'b0000, 4'hF, 512'd0,       -1, 0, 0, 0, 2));
        vecs.push_back(mk("all_ff",      512, 0,  0,  1, 4'b0000, 4'hF, 512'd0,       -1, 0, 0, 0, 128));
        vecs.push_back(mk("crc_line2",   8,  100, 0,  0, 4'b0100, 4'hF, 512'd0,       -1, 1, 0, 0, 2));
        vecs.push_back(mk("overrun_w0",  8,  100, 0,  0, 4'b0000, 4'hF, 512'd1,       -1, 0, 0, 1, 1));
        vecs.push_back(mk("end_bit_e",   8,  100, 0,  0, 4'b0000, 4'hE, 512'd0,       -1, 0, 1, 0, 2));
        vecs.push_back(mk("min_block",   4,  0,   3,  0, 4'b0000, 4'hF, 512'd0,       -1, 0, 0, 0, 1));
        vecs.push_back(mk("crc0_end7",   4,  50,  1,  2, 4'b0001, 4'h7, 512'd0,       -1, 1, 1, 0, 1));
        vecs.push_back(mk("overrun_w3",  16, 9,   0,  2, 4'b0000, 4'hF, 512'd8,       -1, 0, 0, 1, 3));
        vecs.push_back(mk("no_timeout0", 8,  0,   40, 2, 4'b0000, 4'hF, 512'd0,       -1, 0, 0, 0, 2));
        vecs.push_back(mk("to_edge",     8,  11,  10, 2, 4'b0000, 4'hF, 512'd0,       -1, 0, 0, 0, 2));
        for (int r = 0; r < 8; r++) begin
            bs   = 4 * $urandom_range(1, 32);
            nw   = bs / 4;
            gap  = $urandom_range(0, 8);
            to   = ($urandom_range(0, 1) == 0) ? 0 : gap + 1 + $urandom_range(0, 5);
            flip = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            endn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            fm   = '0;
            for (int w = 0; w < nw; w++) if ($urandom_range(0, 3) == 0) fm[w] = 1'b1;
            vecs.push_back(mk($sformatf("rand%0d", r), bs, to, gap, 2, flip, endn, fm, -1,
                              flip != 4'h0, endn != 4'hF, fm != '0, nw - $countones(fm)));
        end

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.block_size = '0;
        bus.timeout    = '0;
        bus.card_in    = 4'hF;
        bus.fifo_full  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_push", 32'(bus.push), 32'd0);
        check("reset_word", bus.word_out, 32'd0);
        check("reset_flags", 32'(flags()), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_block(vecs[i]);
            if (i == 0) begin
                check("basic_word0", (got_q.size() > 0) ? got_q[0] : 32'hx, 32'h04030201);
                check("basic_word1", (got_q.size() > 1) ? got_q[1] : 32'hx, 32'h08070605);
            end
            if (i == 3) run_timeout(20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
